// File: rtl/avm_rd_biu_pkg.sv
// ============================================================================
// Package  : avm_rd_biu_pkg
// Desc     : Shared types and sizing helpers for the Avalon-MM burst read BIU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package avm_rd_biu_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMD  = 1'b1
    } biu_state_t;

    localparam int OW_DEF     = 2;
    localparam int BL_DEF     = 4;
    localparam int FIFO_DEPTH = 2 ** OW_DEF;
    localparam int MAX_BURST  = 2 ** BL_DEF;

    function automatic int pow2(input int e);
        return 1 << e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/avm_rd_len_fifo.sv
// ============================================================================
// Module   : avm_rd_len_fifo
// Desc     : Synchronous FIFO holding the lengths of outstanding bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avm_rd_len_fifo
    import avm_rd_biu_pkg::*;
#(
    parameter int W         = 5,
    parameter int DEPTH_LOG = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int                 DEPTH    = pow2(DEPTH_LOG);
    localparam logic [DEPTH_LOG:0] CNT_FULL = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [W-1:0]         r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_wp;
    logic [DEPTH_LOG-1:0] r_rp;
    logic [DEPTH_LOG:0]   r_cnt;
    logic                 w_pop;
    logic                 w_push;

    // A push into a full FIFO is still legal when the same cycle pops.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + DEPTH_LOG'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + DEPTH_LOG'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (DEPTH_LOG+1)'(1);
                2'b01:   r_cnt <= r_cnt - (DEPTH_LOG+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    assign dout  = r_mem[r_rp];
    assign full  = (r_cnt == CNT_FULL);
    assign empty = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/avm_rd_biu_bst.sv
// ============================================================================
// Module   : avm_rd_biu_bst
// Desc     : Avalon-MM burst read bus interface unit for the DMA read path.
//            Define AVM_RD_BIU_RSPREG_EN to register the response path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avm_rd_biu_bst
    import avm_rd_biu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BL = BL_DEF,
    parameter int OW = OW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] biu_adr,
    input  logic [BL:0]   biu_len,
    input  logic          biu_req,
    output logic          biu_ack,
    output logic          rsp_val,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_eob,
    output logic [AW-1:0] avm_address,
    output logic [BL:0]   avm_burstcount,
    output logic          avm_read,
    input  logic          avm_waitrequest,
    input  logic [DW-1:0] avm_readdata,
    input  logic          avm_readdatavalid,
    output logic          busy,
    output logic          err
);

    localparam logic [OW:0] OTC_LIMIT = {1'b1, {OW{1'b0}}};

    biu_state_t    r_state;
    logic [OW:0]   r_otc;
    logic [BL-1:0] r_beat_cnt;
    logic          r_err;

    logic [BL:0]   w_head;
    logic [BL:0]   w_beat_num;
    logic          w_full;
    logic          w_empty;
    logic          w_ack;
    logic          w_inflight;
    logic          w_beat;
    logic          w_last;
    logic          w_stray;
    logic          w_err_set;

    // A new command may overwrite the command register once the slave takes it.
    assign w_ack = ~rst & biu_req & (biu_len != '0) & (r_otc < OTC_LIMIT) & ~w_full
                 & ((r_state == IDLE) | ~avm_waitrequest);
    assign biu_ack = w_ack;

    assign w_inflight = (r_otc != '0) & ~w_empty;
    assign w_beat     = ~rst & avm_readdatavalid & w_inflight;
    assign w_stray    = ~rst & avm_readdatavalid & ~w_inflight;
    assign w_beat_num = {1'b0, r_beat_cnt} + (BL+1)'(1);
    assign w_last     = w_beat & (w_beat_num == w_head);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ack) begin
                        r_state        <= CMD;
                        avm_read       <= 1'b1;
                        avm_address    <= biu_adr;
                        avm_burstcount <= biu_len;
                    end
                end
                CMD: begin
                    if (~avm_waitrequest) begin
                        if (w_ack) begin
                            avm_address    <= biu_adr;
                            avm_burstcount <= biu_len;
                        end else begin
                            r_state  <= IDLE;
                            avm_read <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_otc      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case ({w_ack, w_last})
                2'b10:   r_otc <= r_otc + (OW+1)'(1);
                2'b01:   r_otc <= r_otc - (OW+1)'(1);
                default: r_otc <= r_otc;
            endcase
            if (w_last) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + BL'(1);
            end
        end
    end

    avm_rd_len_fifo #(
        .W         (BL + 1),
        .DEPTH_LOG (OW)
    ) u_len_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_ack),
        .din   (biu_len),
        .pop   (w_last),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef AVM_RD_BIU_RSPREG_EN
    logic          r_rsp_val;
    logic          r_rsp_eob;
    logic [DW-1:0] r_rsp_dat;
    logic          r_stray;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_val <= 1'b0;
            r_rsp_eob <= 1'b0;
            r_rsp_dat <= '0;
            r_stray   <= 1'b0;
        end else begin
            r_rsp_val <= w_beat;
            r_rsp_eob <= w_last;
            r_rsp_dat <= w_beat ? avm_readdata : '0;
            r_stray   <= w_stray;
        end
    end

    assign rsp_val   = r_rsp_val;
    assign rsp_eob   = r_rsp_eob;
    assign rsp_dat   = r_rsp_dat;
    assign w_err_set = r_stray;
`else
    assign rsp_val   = w_beat;
    assign rsp_eob   = w_last;
    assign rsp_dat   = w_beat ? avm_readdata : '0;
    assign w_err_set = w_stray;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err  = r_err;
    assign busy = (r_state == CMD) | (r_otc != '0);

endmodule

`default_nettype wire

// File: tb/tb_avm_rd_biu_bst.sv
// ============================================================================
// Module   : tb_avm_rd_biu_bst
// Desc     : Scoreboard bench for avm_rd_biu_bst (honours AVM_RD_BIU_RSPREG_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avm_rd_biu_bst;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BL    = 4;
    localparam int OW    = 2;
    localparam int DEPTH = 4;
`ifdef AVM_RD_BIU_RSPREG_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    typedef struct {
        logic [AW-1:0] adr;
        logic [BL:0]   len;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          eob;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] biu_adr;
    logic [BL:0]   biu_len;
    logic          biu_req;
    logic          biu_ack;
    logic          rsp_val;
    logic [DW-1:0] rsp_dat;
    logic          rsp_eob;
    logic [AW-1:0] avm_address;
    logic [BL:0]   avm_burstcount;
    logic          avm_read;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic          busy;
    logic          err;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;
    bit    manual = 1'b1;
    bit    slv_last = 1'b0;
    int    slv_beat = 0;
    int    m_otc = 0;
    bit    m_pend = 1'b0;
    bit    e_ack;
    cmd_t  slv_q[$];
    cmd_t  exp_cmd[$];
    beat_t exp_beat[$];

    always #5 clk = ~clk;

    avm_rd_biu_bst #(.AW(AW), .DW(DW), .BL(BL), .OW(OW)) dut (
        .clk               (clk),
        .rst               (rst),
        .biu_adr           (biu_adr),
        .biu_len           (biu_len),
        .biu_req           (biu_req),
        .biu_ack           (biu_ack),
        .rsp_val           (rsp_val),
        .rsp_dat           (rsp_dat),
        .rsp_eob           (rsp_eob),
        .avm_address       (avm_address),
        .avm_burstcount    (avm_burstcount),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .err               (err)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not seen / unexpected at %0t", name, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One beat from the directed slave, checked after the response latency.
    task automatic beat(input logic [DW-1:0] d, input logic e);
        cyc();
        avm_readdatavalid = 1'b1;
        avm_readdata      = d;
        for (int k = 0; k < RL; k++) begin
            cyc();
            avm_readdatavalid = 1'b0;
        end
        smp();
        chk("beat_val", rsp_val, 1'b1);
        chk("beat_dat", rsp_dat, d);
        chk("beat_eob", rsp_eob, e);
        cyc();
        avm_readdatavalid = 1'b0;
    endtask

    // Random Avalon slave: stalls commands, returns bursts in order with gaps.
    initial begin
        forever begin
            @(negedge clk);
            if (!manual && !rst && avm_read && !avm_waitrequest)
                slv_q.push_back('{adr: avm_address, len: avm_burstcount});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!manual) begin
                avm_waitrequest = ($urandom_range(0, 2) == 0);
                if (slv_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem_word(slv_q[0].adr + 32'(4 * slv_beat));
                    slv_last          = (slv_beat + 1 == int'(slv_q[0].len));
                    if (slv_last) begin
                        void'(slv_q.pop_front());
                        slv_beat = 0;
                    end else begin
                        slv_beat++;
                    end
                end else begin
                    avm_readdatavalid = 1'b0;
                    slv_last          = 1'b0;
                end
            end
        end
    end

    // Reference model and scoreboard monitor for the random phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_otc  = 0;
                m_pend = 1'b0;
                exp_cmd.delete();
                exp_beat.delete();
            end else if (mon_en) begin
                e_ack = biu_req && (biu_len != 0) && (m_otc < DEPTH) && (!m_pend || !avm_waitrequest);
                chk("ack", biu_ack, e_ack);
                chk("avm_read", avm_read, m_pend);
                chk("busy", busy, m_pend || (m_otc != 0));
                chk("err", err, 1'b0);
                if (m_pend) begin
                    if (exp_cmd.size() == 0) begin
                        fail("cmd_extra");
                    end else begin
                        chk("avm_address", avm_address, exp_cmd[0].adr);
                        chk("avm_burstcount", avm_burstcount, exp_cmd[0].len);
                        if (!avm_waitrequest) void'(exp_cmd.pop_front());
                    end
                end
                if (e_ack) begin
                    exp_cmd.push_back('{adr: biu_adr, len: biu_len});
                    for (int i = 0; i < int'(biu_len); i++)
                        exp_beat.push_back('{dat: mem_word(biu_adr + 32'(4 * i)), eob: (i == int'(biu_len) - 1)});
                end
                if (rsp_val) begin
                    if (exp_beat.size() == 0) begin
                        fail("rsp_extra");
                    end else begin
                        chk("rsp_dat", rsp_dat, exp_beat[0].dat);
                        chk("rsp_eob", rsp_eob, exp_beat[0].eob);
                        void'(exp_beat.pop_front());
                    end
                end
                m_otc  = m_otc + (e_ack ? 1 : 0) - ((avm_readdatavalid && slv_last) ? 1 : 0);
                m_pend = e_ack || (m_pend && avm_waitrequest);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        biu_adr           = 32'h1000;
        biu_len           = 5'd4;
        biu_req           = 1'b1;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 32'hFFFF_FFFF;
        avm_readdatavalid = 1'b1;

        // Reset values, with a live request and a stray beat held during reset.
        cyc();
        smp();
        chk("rst_ack", biu_ack, 1'b0);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_bc", avm_burstcount, 5'd0);
        chk("rst_val", rsp_val, 1'b0);
        chk("rst_eob", rsp_eob, 1'b0);
        chk("rst_dat", rsp_dat, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        cyc();
        biu_req           = 1'b0;
        avm_readdatavalid = 1'b0;
        rst               = 1'b0;

        // Single burst of 4 words.
        cyc();
        biu_req = 1'b1;
        smp();
        chk("sb_ack", biu_ack, 1'b1);
        chk("sb_read_pre", avm_read, 1'b0);
        cyc();
        biu_req = 1'b0;
        smp();
        chk("sb_read", avm_read, 1'b1);
        chk("sb_addr", avm_address, 32'h1000);
        chk("sb_bc", avm_burstcount, 5'd4);
        chk("sb_busy", busy, 1'b1);
        cyc();
        smp();
        chk("sb_read_fall", avm_read, 1'b0);
        for (int i = 0; i < 4; i++) begin
            beat($urandom, i == 3);
            smp();
            chk("sb_busy_beat", busy, i != 3);
        end
        chk("sb_err", err, 1'b0);

        // Randomized traffic against the scoreboard.
        mon_en = 1'b1;
        manual = 1'b0;
        for (int n = 0; n < 60; n++) begin
            cyc();
            biu_adr = 32'($urandom) & 32'hFFFF_FFFC;
            biu_len = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 16));
            biu_req = ($urandom_range(0, 4) != 0);
            if (biu_req && biu_len != 0) begin
                int t;
                t = 0;
                smp();
                while (!biu_ack && t < 300) begin
                    smp();
                    t++;
                end
                if (t >= 300) fail("ack_timeout");
            end else begin
                smp();
            end
        end
        cyc();
        biu_req = 1'b0;
        begin
            int t;
            t = 0;
            while ((m_otc != 0 || m_pend || exp_beat.size() != 0) && t < 3000) begin
                smp();
                t++;
            end
            if (t >= 3000) fail("drain_timeout");
        end
        repeat (4) smp();
        mon_en            = 1'b0;
        manual            = 1'b1;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;

        // Waitrequest stall followed by a back-to-back second command.
        cyc();
        biu_adr         = 32'h2000;
        biu_len         = 5'd2;
        biu_req         = 1'b1;
        avm_waitrequest = 1'b1;
        smp();
        chk("stall_ack_idle", biu_ack, 1'b1);
        cyc();
        biu_adr = 32'h3000;
        biu_len = 5'd1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("stall_read", avm_read, 1'b1);
            chk("stall_addr", avm_address, 32'h2000);
            chk("stall_bc", avm_burstcount, 5'd2);
            chk("stall_ack", biu_ack, 1'b0);
            cyc();
        end
        avm_waitrequest = 1'b0;
        smp();
        chk("stall_read4", avm_read, 1'b1);
        chk("stall_addr4", avm_address, 32'h2000);
        chk("stall_ack_go", biu_ack, 1'b1);
        cyc();
        biu_req = 1'b0;
        smp();
        chk("b2b_read", avm_read, 1'b1);
        chk("b2b_addr", avm_address, 32'h3000);
        chk("b2b_bc", avm_burstcount, 5'd1);
        cyc();
        smp();
        chk("stall_read_end", avm_read, 1'b0);
        chk("stall_busy", busy, 1'b1);
        beat($urandom, 1'b0);
        beat($urandom, 1'b1);
        beat($urandom, 1'b1);
        smp();
        chk("stall_busy_end", busy, 1'b0);

        // Outstanding-burst limit.
        cyc();
        biu_req = 1'b1;
        biu_len = 5'd2;
        biu_adr = 32'h4000;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("lim_ack", biu_ack, 1'b1);
            chk("lim_read", avm_read, k != 0);
            if (k != 0) chk("lim_addr", avm_address, 32'h4000 + 32'(16 * (k - 1)));
            cyc();
            biu_adr = biu_adr + 32'h10;
        end
        smp();
        chk("lim_full_ack", biu_ack, 1'b0);
        chk("lim_addr4", avm_address, 32'h4030);
        cyc();
        smp();
        chk("lim_full_ack2", biu_ack, 1'b0);
        chk("lim_read_idle", avm_read, 1'b0);
        cyc();
        avm_readdatavalid = 1'b1;
        avm_readdata      = $urandom;
        smp();
        chk("lim_ack_beat1", biu_ack, 1'b0);
        cyc();
        smp();
        chk("lim_ack_last", biu_ack, 1'b0);
        cyc();
        avm_readdatavalid = 1'b0;
        smp();
        chk("lim_ack_freed", biu_ack, 1'b1);
        cyc();
        biu_req = 1'b0;
        for (int j = 0; j < 8; j++) beat($urandom, (j % 2) == 1);
        smp();
        chk("lim_busy_end", busy, 1'b0);

        // Stray beat with nothing outstanding.
        chk("stray_err_before", err, 1'b0);
        cyc();
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_BEEF;
        for (int k = 0; k < RL; k++) begin
            cyc();
            avm_readdatavalid = 1'b0;
        end
        smp();
        chk("stray_val", rsp_val, 1'b0);
        chk("stray_err_early", err, 1'b0);
        cyc();
        avm_readdatavalid = 1'b0;
        smp();
        chk("stray_err", err, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            smp();
            chk("stray_err_sticky", err, 1'b1);
        end

        // Reset after 2 of 4 beats.
        cyc();
        biu_req = 1'b1;
        biu_adr = 32'h5000;
        biu_len = 5'd4;
        smp();
        chk("rm_ack", biu_ack, 1'b1);
        cyc();
        biu_req = 1'b0;
        beat($urandom, 1'b0);
        beat($urandom, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        smp();
        chk("rm_read", avm_read, 1'b0);
        chk("rm_addr", avm_address, 32'h0);
        chk("rm_bc", avm_burstcount, 5'd0);
        chk("rm_val", rsp_val, 1'b0);
        chk("rm_eob", rsp_eob, 1'b0);
        chk("rm_dat", rsp_dat, 32'h0);
        chk("rm_busy", busy, 1'b0);
        chk("rm_err", err, 1'b0);
        chk("rm_ack0", biu_ack, 1'b0);
        cyc();
        avm_readdatavalid = 1'b1;
        avm_readdata      = $urandom;
        cyc();
        avm_readdatavalid = 1'b0;
        for (int k = 0; k < RL; k++) cyc();
        smp();
        chk("rm_late_beat_err", err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/avm_rd_biu_bst.md
# avm_rd_biu_bst

Avalon-MM burst read bus interface unit placed directly downstream of the single-channel DMA read controller. It accepts one burst command per `biu_req`/`biu_ack` handshake, issues it on an Avalon-MM read master with `avm_read`/`avm_waitrequest`, and tracks up to 2**OW outstanding bursts. It returns each read beat to the DMA data FIFO on `rsp_val`/`rsp_dat`. It also flags protocol violations: a beat arriving with no burst outstanding.

## Interface
- AW, 32: byte address width
- DW, 32: data width in bits; must equal 8*(2**AL) of the DMA controller
- BL, 4: max burst exponent; `biu_len` and `avm_burstcount` are BL+1 bits wide
- OW, 2: outstanding-burst exponent (max 2**OW bursts in flight); OW>=1
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- biu_adr  in  AW  burst start byte address
- biu_len  in  BL+1  burst length in words (1..2**BL)
- biu_req  in  1  command request
- biu_ack  out  1  command accepted; DMA advances address/length on this cycle
- rsp_val  out  1  read beat valid (one word)
- rsp_dat  out  DW  read beat data
- rsp_eob  out  1  qualifies `rsp_val`: last beat of the current burst
- avm_address  out  AW  Avalon address
- avm_burstcount  out  BL+1  Avalon burst count
- avm_read  out  1  Avalon read
- avm_waitrequest  in  1  Avalon waitrequest
- avm_readdata  in  DW  Avalon read data
- avm_readdatavalid  in  1  Avalon read data valid
- busy  out  1  command pending or bursts outstanding
- err  out  1  sticky: beat received with no burst outstanding

## Operation
- FSM states:
  - IDLE: no command pending.
  - CMD: command register valid, `avm_read`=1.
- `biu_ack` = `biu_req` & (`biu_len`!=0) & (`otc` < 2**OW) & (state==IDLE | ~`avm_waitrequest`). It is combinational from the inputs. `biu_req` never depends on `biu_ack`.
- On `biu_ack`:
  - Register `biu_adr`/`biu_len` into `avm_address`/`avm_burstcount`.
  - Push `biu_len` into the length FIFO.
  - `otc` += 1.
  - Next state is CMD.
- In CMD with ~`avm_waitrequest`, the command has been accepted by the slave:
  - If `biu_ack` is asserted in the same cycle, stay in CMD with the new command. This gives back-to-back commands.
  - Otherwise go to IDLE.
- In CMD, `avm_address`, `avm_burstcount` and `avm_read` hold stable while `avm_waitrequest`=1.
- Response side:
  - `beat_cnt` counts `avm_readdatavalid` against the head of the length FIFO.
  - On the beat where `beat_cnt`+1 == head length: `rsp_eob`=1, pop the FIFO, clear `beat_cnt`, and decrement `otc`.
- Simultaneous ack and last beat: `otc` is unchanged, and the FIFO performs push and pop together.
- `avm_readdatavalid` with `otc`==0:
  - The beat is dropped (no `rsp_val`).
  - `err` is set and stays set until `rst`.
- `busy` = (state==CMD) | (`otc`!=0).
- `biu_len`==0 with `biu_req`: no ack and no bus activity.
- `rst` mid-operation: all state clears and in-flight bursts are forgotten. Beats arriving afterwards set `err`, so the bus fabric must be reset together with this block.

## Timing
- Reset values:
  - `avm_read`=0, `avm_address`=0, `avm_burstcount`=0.
  - `rsp_val`=0, `rsp_eob`=0, `rsp_dat`=0.
  - `busy`=0, `err`=0, `biu_ack`=0.
  - FSM=IDLE, `otc`=0, `beat_cnt`=0.
- `avm_read` rises one cycle after `biu_ack`.
- Peak command rate is one burst per cycle while the slave holds `avm_waitrequest`=0.
- Default response path: `rsp_val`/`rsp_dat`/`rsp_eob` are combinational from `avm_readdatavalid`/`avm_readdata`, with zero latency.
- `otc` is OW+1 bits. `beat_cnt` is BL bits. The FIFO is 2**OW deep × (BL+1) bits.

## Configuration
- `AVM_RD_BIU_RSPREG_EN` defined: `rsp_val`, `rsp_dat` and `rsp_eob` are registered, adding 1 cycle of latency. `err` is also set one cycle later. The DMA FIFO headroom accounts for the one extra word.
- `AVM_RD_BIU_RSPREG_EN` undefined: the response path is combinational as described above.

## Structure
- Package `avm_rd_biu_pkg` holds:
  - the FSM state typedef (IDLE, CMD);
  - localparams for FIFO depth (2**OW) and max burst (2**BL).
- Sub-module `avm_rd_len_fifo`:
  - synchronous FIFO, 2**OW × (BL+1);
  - push/pop with simultaneous-operation support;
  - `full`/`empty` flags;
  - pop on empty is ignored.

## Test plan
- Single burst: `biu_adr`=0x1000, `biu_len`=4, slave `avm_waitrequest`=0 → one `biu_ack`; next cycle `avm_read`=1, `avm_address`=0x1000, `avm_burstcount`=4 for one cycle; 4 `rsp_val` pulses with `rsp_eob` on the 4th; `busy` falls after the 4th beat.
- Waitrequest stall: `avm_waitrequest`=1 for 3 cycles → address and burstcount stable; `avm_read` held for 4 cycles; `biu_ack` is 0 during the stall even though `biu_req`=1.
- Outstanding limit with OW=2: 4 bursts of 2 are acked and no data returned → 5th `biu_req` gets no ack. The first last beat frees a slot, and ack occurs the same cycle the count falls.
- Back-to-back: continuous `biu_req`, `avm_waitrequest`=0 → `biu_ack` every cycle and `avm_read` held high with a new address every cycle.
- Stray beat: `avm_readdatavalid`=1 with `otc`=0 → `rsp_val`=0 and `err`=1 stays high until `rst`.
- Reset mid-burst: `rst` after 2 of 4 beats → all outputs return to reset values the next cycle.
